// File: rtl/airi5c_dec_queue_if.sv
// airi5c_dec_queue_if: fetch-side and decode-side handshake bundle of the decode queue.
interface airi5c_dec_queue_if #(
    parameter int XLEN = 32,
    parameter int ITW  = 2
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [XLEN-1:0] in_inst_i;
    logic [XLEN-1:0] in_pc_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] inst_o;
    logic [XLEN-1:0] pc_o;
    logic [ITW-1:0]  imm_type_o;
    logic            imm_used_o;
    logic            is_branch_o;
    logic            illegal_o;
    logic [1:0]      count_o;

    modport master (
        output in_valid_i, in_inst_i, in_pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, inst_o, pc_o, imm_type_o,
               imm_used_o, is_branch_o, illegal_o, count_o
    );

    modport slave (
        input  in_valid_i, in_inst_i, in_pc_i, out_ready_i,
        output in_ready_o, out_valid_o, inst_o, pc_o, imm_type_o,
               imm_used_o, is_branch_o, illegal_o, count_o
    );
endinterface

// File: rtl/airi5c_dec_queue.sv
// airi5c_dec_queue: two-entry fetch-to-decode queue that pre-classifies each word's immediate type.
module airi5c_dec_queue #(
    parameter int XLEN = 32,
    parameter int ITW  = 2
) (
    input logic              clk_i,
    input logic              rst_ni,
    input logic              flush_i,
    airi5c_dec_queue_if.slave q
);
    localparam logic [ITW-1:0] IMM_I = ITW'(0);
    localparam logic [ITW-1:0] IMM_S = ITW'(1);
    localparam logic [ITW-1:0] IMM_U = ITW'(2);
    localparam logic [ITW-1:0] IMM_J = ITW'(3);

    logic [XLEN-1:0] inst_q [2];
    logic [XLEN-1:0] pc_q   [2];
    logic [ITW-1:0]  type_q [2];
    logic [2:0]      flag_q [2];
    logic            wp, rp;
    logic [1:0]      count;
    logic            push, pop;
    logic [ITW-1:0]  type_d;
    logic            used_d, branch_d, illegal_d;

    assign q.in_ready_o  = count != 2'd2;
    assign q.out_valid_o = count != 2'd0;
    assign push          = q.in_valid_i & q.in_ready_o;
    assign pop           = q.out_valid_o & q.out_ready_i;

    // Compressed encodings never match a listed opcode, so they fall into the illegal default.
    always_comb begin
        type_d    = IMM_I;
        used_d    = 1'b1;
        branch_d  = 1'b0;
        illegal_d = q.in_inst_i[1:0] != 2'b11;
        case (q.in_inst_i[6:0])
            7'b0000011, 7'b0010011, 7'b0001111, 7'b1100111, 7'b1110011: ;
            7'b0100011: type_d = IMM_S;
            7'b1100011: begin
                type_d   = IMM_S;
                branch_d = 1'b1;
            end
            7'b0110111, 7'b0010111: type_d = IMM_U;
            7'b1101111: type_d = IMM_J;
            7'b0110011: used_d = 1'b0;
            default: begin
                used_d    = 1'b0;
                illegal_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp    <= 1'b0;
            rp    <= 1'b0;
            count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
                type_q[i] <= IMM_I;
                flag_q[i] <= '0;
            end
        end else if (flush_i) begin
            wp    <= 1'b0;
            rp    <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                inst_q[wp] <= q.in_inst_i;
                pc_q[wp]   <= q.in_pc_i;
                type_q[wp] <= type_d;
                flag_q[wp] <= {used_d, branch_d, illegal_d};
                wp         <= ~wp;
            end
            if (pop) rp <= ~rp;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign q.inst_o      = inst_q[rp];
    assign q.pc_o        = pc_q[rp];
    assign q.imm_type_o  = type_q[rp];
    assign q.imm_used_o  = flag_q[rp][2];
    assign q.is_branch_o = flag_q[rp][1];
    assign q.illegal_o   = flag_q[rp][0];
    assign q.count_o     = count;
endmodule

// File: tb/tb_airi5c_dec_queue.sv
// tb_airi5c_dec_queue: directed plus randomized checks of the decode queue against a queue-based model.
module tb_airi5c_dec_queue;
    logic clk, rst_n, flush;
    int   checks, failures;
    logic [63:0] mq[$];

    airi5c_dec_queue_if #(.XLEN(32), .ITW(2)) bus();
    airi5c_dec_queue #(.XLEN(32), .ITW(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .q(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Returns {imm_type[1:0], used, branch, illegal} from the opcode table.
    function automatic logic [4:0] cls(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        if (op inside {7'h03, 7'h13, 7'h0F, 7'h67, 7'h73}) return 5'b00_1_0_0;
        if (op == 7'h23) return 5'b01_1_0_0;
        if (op == 7'h63) return 5'b01_1_1_0;
        if (op inside {7'h37, 7'h17}) return 5'b10_1_0_0;
        if (op == 7'h6F) return 5'b11_1_0_0;
        if (op == 7'h33) return 5'b00_0_0_0;
        return 5'b00_0_0_1;
    endfunction

    task automatic check_out();
        logic [4:0] c;
        chk("count", 64'(bus.count_o), 64'(mq.size()));
        chk("out_valid", 64'(bus.out_valid_o), 64'(mq.size() != 0));
        chk("in_ready", 64'(bus.in_ready_o), 64'(mq.size() != 2));
        if (mq.size() != 0) begin
            c = cls(mq[0][63:32]);
            chk("inst", 64'(bus.inst_o), 64'(mq[0][63:32]));
            chk("pc", 64'(bus.pc_o), 64'(mq[0][31:0]));
            chk("imm_type", 64'(bus.imm_type_o), 64'(c[4:3]));
            chk("imm_used", 64'(bus.imm_used_o), 64'(c[2]));
            chk("is_branch", 64'(bus.is_branch_o), 64'(c[1]));
            chk("illegal", 64'(bus.illegal_o), 64'(c[0]));
        end
    endtask

    task automatic check_reset();
        chk("rst_count", 64'(bus.count_o), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
        chk("rst_inst", 64'(bus.inst_o), 64'd0);
        chk("rst_pc", 64'(bus.pc_o), 64'd0);
        chk("rst_imm_type", 64'(bus.imm_type_o), 64'd0);
        chk("rst_flags", 64'({bus.imm_used_o, bus.is_branch_o, bus.illegal_o}), 64'd0);
    endtask

    task automatic step(input logic v, input logic [31:0] w, input logic [31:0] pc,
                        input logic r, input logic f);
        bit push, pop;
        @(negedge clk);
        bus.in_valid_i  = v;
        bus.in_inst_i   = w;
        bus.in_pc_i     = pc;
        bus.out_ready_i = r;
        flush           = f;
        chk("pre_in_ready", 64'(bus.in_ready_o), 64'(mq.size() != 2));
        push = v && mq.size() != 2;
        pop  = r && mq.size() != 0;
        @(posedge clk);
        #1;
        if (f) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back({w, pc});
        end
        check_out();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [13] = '{7'h03, 7'h13, 7'h0F, 7'h67, 7'h73, 7'h23, 7'h63,
                                  7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F, 7'h01};
        logic [31:0] w;
        w = $urandom();
        if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 12)];
        return w;
    endfunction

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.in_valid_i = 1'b0;
        bus.in_inst_i = '0;
        bus.in_pc_i = '0;
        bus.out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_reset();
        @(negedge clk) rst_n = 1'b1;

        step(1, 32'h00500093, 32'h80, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 32'h00112023, 32'h84, 0, 0);
        step(1, 32'h0080006F, 32'h88, 0, 0);
        step(1, 32'h00000013, 32'h8C, 0, 0);
        step(1, 32'h00000013, 32'h8C, 1, 0);
        step(1, 32'h00000013, 32'h8C, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        step(1, 32'h00500093, 32'h100, 0, 0);
        for (int i = 0; i < 4; i++)
            step(1, 32'h123450B7 + (i << 12), 32'h104 + 4 * i, 1, 0);
        step(0, 0, 0, 1, 0);

        step(1, 32'h00208463, 32'h200, 1, 0);
        step(1, 32'h002081B3, 32'h204, 1, 0);
        step(1, 32'h0000007F, 32'h208, 1, 0);
        step(1, 32'h00004501, 32'h20C, 1, 0);
        step(0, 0, 0, 1, 0);

        step(1, 32'h00112023, 32'h300, 0, 0);
        step(1, 32'h00208463, 32'h304, 0, 0);
        step(1, 32'hDEADBEB7, 32'h308, 1, 1);
        step(0, 0, 0, 1, 0);
        step(1, 32'h00500093, 32'h30C, 0, 0);
        step(0, 0, 0, 1, 0);

        step(1, 32'h00112023, 32'h400, 0, 0);
        step(1, 32'h0080006F, 32'h404, 0, 0);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        bus.out_ready_i = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset();
        mq.delete();
        @(negedge clk) rst_n = 1'b1;
        step(1, 32'h123450B7, 32'h500, 0, 0);
        step(0, 0, 0, 1, 0);

        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 3) != 0, rand_inst(), $urandom(),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
